// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - 16x oversampled UART receiver with optional parity
// Start bit is qualified at mid-bit; data, parity and stop are sampled 16 ticks apart from there.
module uart_rx_oversampled #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [3:0] MID_TICK  = 4'd7;
  localparam logic [3:0] BIT_LAST  = 4'd15;
  localparam logic [3:0] STOP_LAST = 4'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
  localparam logic       PAR_EN    = (PARITY_EN != 0);
  localparam logic       PAR_ODD   = (PARITY_ODD != 0);

  state_t          state, state_next;
  logic [3:0]      s_cnt, s_cnt_next;
  logic [2:0]      n, n_next;
  logic [DBIT-1:0] sreg, sreg_next;
  logic            p, p_next;
  logic [DBIT-1:0] dout_next;
  logic            done_next, perr_next, ferr_next;
  logic            rx_meta, rx_s;

  // rx is asynchronous to clk; both flops idle high so reset never looks like a start bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s_cnt        <= '0;
      n            <= '0;
      sreg         <= '0;
      p            <= 1'b0;
      rx_dout      <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_next;
      s_cnt        <= s_cnt_next;
      n            <= n_next;
      sreg         <= sreg_next;
      p            <= p_next;
      rx_dout      <= dout_next;
      rx_done_tick <= done_next;
      parity_err   <= perr_next;
      frame_err    <= ferr_next;
    end
  end

  always_comb begin
    state_next = state;
    s_cnt_next = s_cnt;
    n_next     = n;
    sreg_next  = sreg;
    p_next     = p;
    dout_next  = rx_dout;
    perr_next  = parity_err;
    ferr_next  = frame_err;
    done_next  = 1'b0;

    case (state)
      IDLE: begin
        // start tracking immediately, ticks in IDLE carry no timing information
        if (!rx_s) begin
          state_next = START;
          s_cnt_next = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_cnt == MID_TICK) begin
            if (!rx_s) begin
              state_next = DATA;
              s_cnt_next = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_cnt_next = s_cnt + 4'd1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_cnt == BIT_LAST) begin
            s_cnt_next = '0;
            sreg_next  = {rx_s, sreg[DBIT-1:1]};
            if (n == N_LAST) begin
              state_next = PAR_EN ? PARITY : STOP;
            end else begin
              n_next = n + 3'd1;
            end
          end else begin
            s_cnt_next = s_cnt + 4'd1;
          end
        end
      end

      PARITY: begin
        if (s_tick) begin
          if (s_cnt == BIT_LAST) begin
            s_cnt_next = '0;
            p_next     = rx_s;
            state_next = STOP;
          end else begin
            s_cnt_next = s_cnt + 4'd1;
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_cnt == STOP_LAST) begin
            dout_next  = sreg;
            ferr_next  = ~rx_s;
            perr_next  = PAR_EN & ((^sreg ^ p) != PAR_ODD);
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            s_cnt_next = s_cnt + 4'd1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
